// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl
// Sequences a WIDTH-bit serial-in/parallel-out capture. Serial bits are
// qualified by sin_vld, frames are aligned on sync, stalled frames are timed
// out, and each completed word is handed downstream through a registered
// valid/ready output stage. The block owns the shift register and bit counter.
//
// Optional feature: define SIPO_PARITY_EN to append an even-parity bit to each
// frame (WIDTH+1 bits, PAR state, par_err reported with the word). Without the
// macro, frames are WIDTH bits and par_err is tied low.
//
// Parameters:
//   WIDTH   - data word width, 2..32
//   TIMEOUT - idle clocks allowed between strobes inside a frame, 0 = never
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   sin       - serial data bit, sampled when sin_vld=1
//   sin_vld   - bit strobe
//   sync      - start-of-frame marker, qualified by sin_vld
//   dout      - completed parallel word (first bit received lands in MSB)
//   dout_vld  - dout holds an unconsumed word
//   dout_rdy  - consumer accepts dout
//   busy      - frame in progress
//   frm_err   - one-cycle pulse on frame abort (resync or timeout)
//   ovr       - sticky overrun flag, cleared by ovr_clr
//   ovr_clr   - clears ovr (a simultaneous new overrun wins)
//   par_err   - parity mismatch for the current dout word
module sipo_rx_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             busy,
    output logic             frm_err,
    output logic             ovr,
    input  logic             ovr_clr,
    output logic             par_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_PAR   = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [CW-1:0]    bit_cnt, cnt_nx;
    logic [TW-1:0]    to_cnt, to_nx;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] done_word;
    logic             done;
    logic             abort;
    logic             can_load;

`ifdef SIPO_PARITY_EN
    logic done_par;
    logic par_q;
`endif

    assign shifted  = {sreg[WIDTH-2:0], sin};
    // A new word may load if the output slot is empty or is being drained now.
    assign can_load = !dout_vld || dout_rdy;

    always_comb begin
        state_nx  = state;
        sreg_nx   = sreg;
        cnt_nx    = bit_cnt;
        to_nx     = to_cnt;
        done      = 1'b0;
        abort     = 1'b0;
        done_word = shifted;
`ifdef SIPO_PARITY_EN
        done_par  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (sin_vld && sync) begin
                    sreg_nx  = shifted;
                    cnt_nx   = CW'(1);
                    to_nx    = '0;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT, S_PAR: begin
                if (sin_vld) begin
                    to_nx = '0;
                    if (sync) begin
                        // Resync: the aborting bit becomes bit 1 of a new frame.
                        abort    = 1'b1;
                        sreg_nx  = shifted;
                        cnt_nx   = CW'(1);
                        state_nx = S_SHIFT;
                    end
`ifdef SIPO_PARITY_EN
                    else if (state == S_PAR) begin
                        // sreg already holds the data; sin is the parity bit.
                        done      = 1'b1;
                        done_word = sreg;
                        done_par  = ^{sreg, sin};
                        cnt_nx    = '0;
                        state_nx  = S_IDLE;
                    end
`endif
                    else if (bit_cnt == CW'(WIDTH - 1)) begin
                        sreg_nx = shifted;
                        cnt_nx  = '0;
`ifdef SIPO_PARITY_EN
                        state_nx = S_PAR;
`else
                        done     = 1'b1;
                        state_nx = S_IDLE;
`endif
                    end else begin
                        sreg_nx = shifted;
                        cnt_nx  = bit_cnt + CW'(1);
                    end
                end else if ((TIMEOUT != 0) && (to_cnt == TW'(TIMEOUT - 1))) begin
                    // This idle clock is the TIMEOUT-th in a row: drop the frame.
                    abort    = 1'b1;
                    sreg_nx  = '0;
                    cnt_nx   = '0;
                    to_nx    = '0;
                    state_nx = S_IDLE;
                end else begin
                    to_nx = to_cnt + TW'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
            frm_err  <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            bit_cnt <= cnt_nx;
            to_cnt  <= to_nx;
            busy    <= (state_nx != S_IDLE);
            frm_err <= abort;

            if (done && can_load) begin
                dout     <= done_word;
                dout_vld <= 1'b1;
            end else if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end

            // A word arriving into a full, stalled output slot is dropped.
            if (done && !can_load) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (done && can_load) begin
            par_q <= done_par;
        end
    end
    assign par_err = par_q;
`else
    assign par_err = 1'b0;
`endif

endmodule
